// File: rtl/qgemm_fifo_pkg.sv
// Shared definitions for the qgemm scale FIFOs: width helpers and the
// default matrix geometry used by the scale generator path.
package qgemm_fifo_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic int unsigned row_w(input int unsigned elem_w, input int unsigned mat);
      return elem_w * mat;
   endfunction

   function automatic int unsigned mat_w(input int unsigned elem_w, input int unsigned mat);
      return elem_w * mat * mat;
   endfunction

   localparam int unsigned MAT_SIZE_DEF  = 16;
   localparam int unsigned FP_MANT_W_DEF = 23;
   localparam int unsigned FP_EXP_W_DEF  = 8;

   localparam int unsigned MANT_ROW_W = row_w(FP_MANT_W_DEF, MAT_SIZE_DEF);
   localparam int unsigned EXP_ROW_W  = row_w(FP_EXP_W_DEF, MAT_SIZE_DEF);
   localparam int unsigned MANT_MAT_W = mat_w(FP_MANT_W_DEF, MAT_SIZE_DEF);
   localparam int unsigned EXP_MAT_W  = mat_w(FP_EXP_W_DEF, MAT_SIZE_DEF);

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for a DEPTH-entry FIFO (any DEPTH >= 2),
// with synchronous flush taking priority over push and pop.
module fifo_ptr_ctrl
   import qgemm_fifo_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
   localparam int unsigned CW    = clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rstnn,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   output logic [AW-1:0] head_o,
   output logic [AW-1:0] tail_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_en, pop_en;

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_en = push_i & ~full_o;
   assign pop_en  = pop_i & ~empty_o;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_en) tail_d = wrap_inc(tail_q);
         if (pop_en)  head_d = wrap_inc(head_q);
         if (push_en && !pop_en)      count_d = count_q + CW'(1);
         else if (pop_en && !push_en) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_o  = head_q;
   assign tail_o  = tail_q;
   assign count_o = count_q;

endmodule

// File: rtl/scale_fifo_rowstream.sv
// Show-ahead FIFO of whole scale matrices; each head entry is streamed out
// as MAT_SIZE/ROWS_PER_BEAT row-beats and popped after its last beat.
module scale_fifo_rowstream
   import qgemm_fifo_pkg::*;
#(
   parameter  int unsigned MAT_SIZE      = MAT_SIZE_DEF,
   parameter  int unsigned FP_MANT_W     = FP_MANT_W_DEF,
   parameter  int unsigned FP_EXP_W      = FP_EXP_W_DEF,
   parameter  int unsigned DEPTH         = 4,
   parameter  int unsigned ROWS_PER_BEAT = 1,
   localparam int unsigned BEATS         = MAT_SIZE / ROWS_PER_BEAT,
   localparam int unsigned CW            = clog2(DEPTH + 1),
   localparam int unsigned BW            = (clog2(BEATS) > 0) ? clog2(BEATS) : 1,
   localparam int unsigned MANT_RW       = row_w(FP_MANT_W, MAT_SIZE) * ROWS_PER_BEAT,
   localparam int unsigned EXP_RW        = row_w(FP_EXP_W, MAT_SIZE) * ROWS_PER_BEAT,
   localparam int unsigned MANT_MW       = mat_w(FP_MANT_W, MAT_SIZE),
   localparam int unsigned EXP_MW        = mat_w(FP_EXP_W, MAT_SIZE)
) (
   input  logic               clk,
   input  logic               rstnn,
   input  logic               wr_valid_i,
   output logic               wr_ready_o,
   input  logic [MANT_MW-1:0] mant_in_i,
   input  logic [EXP_MW-1:0]  exp_in_i,
   output logic               rd_valid_o,
   input  logic               rd_ready_i,
   output logic [MANT_RW-1:0] mant_out_o,
   output logic [EXP_RW-1:0]  exp_out_o,
   output logic [BW-1:0]      rd_beat_o,
   output logic               rd_last_o,
   input  logic               flush_i,
   input  logic               err_clr_i,
   input  logic [CW-1:0]      afull_thr_i,
   input  logic [CW-1:0]      aempty_thr_i,
   output logic [CW-1:0]      count_o,
   output logic               empty_o,
   output logic               full_o,
   output logic               almost_full_o,
   output logic               almost_empty_o,
   output logic               ovf_o
);

   localparam int unsigned AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

   logic [MANT_MW-1:0] mant_mem_q [DEPTH];
   logic [EXP_MW-1:0]  exp_mem_q  [DEPTH];
   logic [MANT_MW-1:0] head_mant;
   logic [EXP_MW-1:0]  head_exp;
   logic [AW-1:0]      head, tail;
   logic [CW-1:0]      count;
   logic               full, empty;
   logic [BW-1:0]      beat_q, beat_d;
   logic               ovf_q, ovf_d;
   logic               push, beat_acc, last_beat;

   assign push      = wr_valid_i & ~full & ~flush_i;
   assign beat_acc  = ~empty & rd_ready_i;
   assign last_beat = (beat_q == BW'(BEATS - 1));

   fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
      .clk     (clk),
      .rstnn   (rstnn),
      .flush_i (flush_i),
      .push_i  (push),
      .pop_i   (beat_acc & last_beat),
      .head_o  (head),
      .tail_o  (tail),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   // Storage is deliberately unreset; outputs are only meaningful while rd_valid_o.
   always_ff @(posedge clk) begin
      if (push) begin
         mant_mem_q[tail] <= mant_in_i;
         exp_mem_q[tail]  <= exp_in_i;
      end
   end

   always_comb begin
      beat_d = beat_q;
      if (flush_i)       beat_d = '0;
      else if (beat_acc) beat_d = last_beat ? '0 : beat_q + BW'(1);
   end

   // Set beats clear so an overflow coinciding with err_clr/flush is not lost.
   always_comb begin
      ovf_d = (wr_valid_i & full) | (ovf_q & ~err_clr_i & ~flush_i);
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         beat_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         beat_q <= beat_d;
         ovf_q  <= ovf_d;
      end
   end

   assign head_mant = mant_mem_q[head];
   assign head_exp  = exp_mem_q[head];

   always_comb begin
      mant_out_o = head_mant[MANT_RW-1:0];
      exp_out_o  = head_exp[EXP_RW-1:0];
      for (int unsigned b = 1; b < BEATS; b++) begin
         if (beat_q == BW'(b)) begin
            mant_out_o = head_mant[b*MANT_RW +: MANT_RW];
            exp_out_o  = head_exp[b*EXP_RW +: EXP_RW];
         end
      end
   end

   assign wr_ready_o     = ~full;
   assign rd_valid_o     = ~empty;
   assign rd_beat_o      = beat_q;
   assign rd_last_o      = ~empty & last_beat;
   assign count_o        = count;
   assign empty_o        = empty;
   assign full_o         = full;
   assign almost_full_o  = (count >= afull_thr_i);
   assign almost_empty_o = (count <= aempty_thr_i);
   assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_scale_fifo_rowstream.sv
// Bench for scale_fifo_rowstream: queue-based reference model, directed
// corner sequences, a threshold vector table and a whole-matrix-pop instance.
module tb_scale_fifo_rowstream;

   localparam int unsigned MAT   = 4;
   localparam int unsigned MW    = 23;
   localparam int unsigned EW    = 8;
   localparam int unsigned D     = 3;
   localparam int unsigned BEATS = 4;
   localparam int unsigned MROW  = MW * MAT;
   localparam int unsigned EROW  = EW * MAT;
   localparam int unsigned MMAT  = MROW * MAT;
   localparam int unsigned EMAT  = EROW * MAT;
   localparam int unsigned CW    = 2;

   typedef struct packed {
      logic [MMAT-1:0] m;
      logic [EMAT-1:0] e;
   } mat_t;

   typedef struct {
      bit            wv;
      logic [CW-1:0] aft;
      logic [CW-1:0] aet;
      int            cnt;
      bit            af;
      bit            ae;
   } vec_t;

   logic            clk = 1'b0;
   logic            rstnn;
   logic            wr_valid, rd_ready, flush, err_clr;
   logic [MMAT-1:0] mant_in;
   logic [EMAT-1:0] exp_in;
   logic [CW-1:0]   afull_thr, aempty_thr;
   logic            wr_ready, rd_valid, rd_last, empty, full, afull, aempty, ovf;
   logic [MROW-1:0] mant_out;
   logic [EROW-1:0] exp_out;
   logic [1:0]      rd_beat;
   logic [CW-1:0]   count;

   logic            wr_valid2, rd_ready2;
   logic            wr_ready2, rd_valid2, rd_last2, empty2, full2, afull2, aempty2, ovf2;
   logic [MMAT-1:0] mant_out2;
   logic [EMAT-1:0] exp_out2;
   logic [0:0]      rd_beat2;
   logic [CW-1:0]   count2;

   always #5 clk = ~clk;

   scale_fifo_rowstream #(
      .MAT_SIZE(MAT), .FP_MANT_W(MW), .FP_EXP_W(EW), .DEPTH(D), .ROWS_PER_BEAT(1)
   ) u_dut (
      .clk(clk), .rstnn(rstnn), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
      .mant_in_i(mant_in), .exp_in_i(exp_in), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
      .mant_out_o(mant_out), .exp_out_o(exp_out), .rd_beat_o(rd_beat), .rd_last_o(rd_last),
      .flush_i(flush), .err_clr_i(err_clr), .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr),
      .count_o(count), .empty_o(empty), .full_o(full), .almost_full_o(afull),
      .almost_empty_o(aempty), .ovf_o(ovf)
   );

   scale_fifo_rowstream #(
      .MAT_SIZE(MAT), .FP_MANT_W(MW), .FP_EXP_W(EW), .DEPTH(D), .ROWS_PER_BEAT(4)
   ) u_dut_whole (
      .clk(clk), .rstnn(rstnn), .wr_valid_i(wr_valid2), .wr_ready_o(wr_ready2),
      .mant_in_i(mant_in), .exp_in_i(exp_in), .rd_valid_o(rd_valid2), .rd_ready_i(rd_ready2),
      .mant_out_o(mant_out2), .exp_out_o(exp_out2), .rd_beat_o(rd_beat2), .rd_last_o(rd_last2),
      .flush_i(flush), .err_clr_i(err_clr), .afull_thr_i(afull_thr), .aempty_thr_i(aempty_thr),
      .count_o(count2), .empty_o(empty2), .full_o(full2), .almost_full_o(afull2),
      .almost_empty_o(aempty2), .ovf_o(ovf2)
   );

   mat_t q[$];
   int   beat_m;
   bit   ovf_m;
   int   pushed_n;
   int   n_pass   = 0;
   int   n_checks = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic mat_t pat_mat();
      mat_t p;
      p = '0;
      for (int r = 0; r < MAT; r++)
         for (int c = 0; c < MAT; c++) begin
            p.m |= MMAT'(16 * r + c) << ((r * MAT + c) * MW);
            p.e |= EMAT'(16 * r + c) << ((r * MAT + c) * EW);
         end
      return p;
   endfunction

   function automatic mat_t rand_mat();
      mat_t p;
      p = '0;
      for (int i = 0; i < MAT * MAT; i++) begin
         p.m |= MMAT'($urandom_range(0, (1 << MW) - 1)) << (i * MW);
         p.e |= EMAT'($urandom_range(0, (1 << EW) - 1)) << (i * EW);
      end
      return p;
   endfunction

   task automatic set_mat(input mat_t p);
      mant_in = p.m;
      exp_in  = p.e;
   endtask

   // Reference behaviour at one rising edge, from the inputs held across it.
   task automatic model_edge();
      bit full_m;
      mat_t nm;
      full_m = (q.size() == D);
      nm.m = mant_in;
      nm.e = exp_in;
      if (flush) begin
         q.delete();
         beat_m = 0;
         ovf_m  = wr_valid && full_m;
      end else begin
         ovf_m = (wr_valid && full_m) || (ovf_m && !err_clr);
         if (rd_ready && q.size() > 0) begin
            if (beat_m == BEATS - 1) begin
               void'(q.pop_front());
               beat_m = 0;
            end else beat_m++;
         end
         if (wr_valid && !full_m) begin
            q.push_back(nm);
            pushed_n++;
         end
      end
   endtask

   task automatic check_model(input string tag);
      int n;
      mat_t h;
      n = q.size();
      chk({tag, " count"}, count, n);
      chk({tag, " rd_valid"}, rd_valid, n > 0);
      chk({tag, " wr_ready"}, wr_ready, n < D);
      chk({tag, " empty"}, empty, n == 0);
      chk({tag, " full"}, full, n == D);
      chk({tag, " rd_beat"}, rd_beat, beat_m);
      chk({tag, " rd_last"}, rd_last, (n > 0) && (beat_m == BEATS - 1));
      chk({tag, " ovf"}, ovf, ovf_m);
      chk({tag, " afull"}, afull, n >= int'(afull_thr));
      chk({tag, " aempty"}, aempty, n <= int'(aempty_thr));
      if (n > 0) begin
         h = q[0];
         chk({tag, " mant"}, mant_out, MROW'(h.m >> (beat_m * MROW)));
         chk({tag, " exp"}, exp_out, EROW'(h.e >> (beat_m * EROW)));
      end
   endtask

   task automatic cycle(input string tag);
      #1;
      check_model(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_in(input bit wv, input bit rr, input bit fl, input bit ec);
      wr_valid = wv;
      rd_ready = rr;
      flush    = fl;
      err_clr  = ec;
   endtask

   initial begin
      vec_t tbl[6];
      mat_t p;
      logic [MROW-1:0] row;
      bit done;

      tbl[0] = '{wv: 1, aft: 2, aet: 0, cnt: 0, af: 0, ae: 1};
      tbl[1] = '{wv: 1, aft: 2, aet: 0, cnt: 1, af: 0, ae: 0};
      tbl[2] = '{wv: 1, aft: 2, aet: 0, cnt: 2, af: 1, ae: 0};
      tbl[3] = '{wv: 0, aft: 2, aet: 0, cnt: 3, af: 1, ae: 0};
      tbl[4] = '{wv: 0, aft: 3, aet: 3, cnt: 3, af: 1, ae: 1};
      tbl[5] = '{wv: 0, aft: 0, aet: 2, cnt: 3, af: 1, ae: 0};

      rstnn = 1'b0;
      set_in(0, 0, 0, 0);
      wr_valid2 = 1'b0;
      rd_ready2 = 1'b0;
      afull_thr = 2;
      aempty_thr = 0;
      set_mat(rand_mat());
      q.delete();
      beat_m = 0;
      ovf_m = 0;
      @(negedge clk);
      @(negedge clk);
      rstnn = 1'b1;
      #1;
      chk("reset wr_ready", wr_ready, 1);
      chk("reset rd_valid", rd_valid, 0);
      chk("reset empty", empty, 1);
      chk("reset full", full, 0);
      chk("reset count", count, 0);
      chk("reset rd_beat", rd_beat, 0);
      chk("reset rd_last", rd_last, 0);
      chk("reset ovf", ovf, 0);

      // Single matrix streamed row by row
      p = pat_mat();
      set_mat(p);
      set_in(1, 1, 0, 0);
      cycle("t1 push");
      set_in(0, 1, 0, 0);
      for (int b = 0; b < BEATS; b++) begin
         row = '0;
         for (int c = 0; c < MAT; c++) row |= MROW'(16 * b + c) << (c * MW);
         #1;
         chk("t1 beat idx", rd_beat, b);
         chk("t1 row mant", mant_out, row);
         chk("t1 last", rd_last, b == BEATS - 1);
         cycle("t1 beat");
      end
      #1;
      chk("t1 empty after", empty, 1);
      cycle("t1 end");

      // Fill, overflow, clear
      for (int i = 0; i < D; i++) begin
         set_mat(rand_mat());
         set_in(1, 0, 0, 0);
         cycle("t2 fill");
      end
      set_mat(rand_mat());
      cycle("t2 overflow");
      set_in(0, 0, 0, 0);
      #1;
      chk("t2 ovf set", ovf, 1);
      chk("t2 count full", count, D);
      cycle("t2 hold");
      set_in(0, 0, 0, 1);
      cycle("t2 err_clr");
      set_in(0, 0, 0, 0);
      #1;
      chk("t2 ovf cleared", ovf, 0);
      cycle("t2 after clr");

      // Full with the consumer reaching its last beat while a write waits
      set_mat(rand_mat());
      for (int i = 0; i < 5; i++) begin
         set_in(1, 1, 0, 0);
         cycle("t3 held write");
      end
      set_in(0, 1, 0, 0);
      for (int i = 0; i < D * BEATS + 2; i++) cycle("t3 drain");

      // Randomly throttled traffic, six entries
      pushed_n = 0;
      done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         set_mat(rand_mat());
         set_in((pushed_n < 6) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1, 0, 0);
         cycle("t4 random");
         done = (pushed_n >= 6) && (q.size() == 0);
      end
      chk("t4 completed", done, 1);

      // Flush mid-entry with a concurrent push
      set_in(1, 0, 0, 0);
      set_mat(rand_mat());
      cycle("t5 push a");
      set_mat(rand_mat());
      cycle("t5 push b");
      set_in(0, 1, 0, 0);
      cycle("t5 beat0");
      cycle("t5 beat1");
      #1;
      chk("t5 at beat2", rd_beat, 2);
      set_mat(rand_mat());
      set_in(1, 1, 1, 0);
      cycle("t5 flush");
      set_in(0, 0, 0, 0);
      #1;
      chk("t5 count", count, 0);
      chk("t5 rd_beat", rd_beat, 0);
      chk("t5 ovf", ovf, 0);
      set_mat(rand_mat());
      set_in(1, 1, 0, 0);
      cycle("t5 repush");
      set_in(0, 1, 0, 0);
      for (int i = 0; i < BEATS + 1; i++) cycle("t5 reread");

      // Threshold table
      set_in(0, 0, 1, 0);
      cycle("t6 flush");
      for (int i = 0; i < 6; i++) begin
         set_mat(rand_mat());
         set_in(tbl[i].wv, 0, 0, 0);
         afull_thr  = tbl[i].aft;
         aempty_thr = tbl[i].aet;
         #1;
         chk("t6 count", count, tbl[i].cnt);
         chk("t6 almost_full", afull, tbl[i].af);
         chk("t6 almost_empty", aempty, tbl[i].ae);
         @(posedge clk);
         model_edge();
         @(negedge clk);
      end
      afull_thr  = 2;
      aempty_thr = 0;

      // Whole-matrix pop instance
      set_in(0, 0, 1, 0);
      cycle("t7 flush");
      set_in(0, 0, 0, 0);
      p = rand_mat();
      set_mat(p);
      wr_valid2 = 1'b1;
      #1;
      chk("t7 no read-through", rd_valid2, 0);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      wr_valid2 = 1'b0;
      set_mat(rand_mat());
      #1;
      chk("t7 rd_valid", rd_valid2, 1);
      chk("t7 rd_beat", rd_beat2, 0);
      chk("t7 rd_last", rd_last2, 1);
      chk("t7 mant", mant_out2, p.m);
      chk("t7 exp", exp_out2, p.e);
      chk("t7 count", count2, 1);
      rd_ready2 = 1'b1;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      rd_ready2 = 1'b0;
      #1;
      chk("t7 empty", empty2, 1);
      chk("t7 count after", count2, 0);

      // Asynchronous reset mid-stream
      set_mat(rand_mat());
      set_in(1, 0, 0, 0);
      cycle("t8 push");
      set_in(1, 1, 0, 0);
      cycle("t8 push2");
      set_in(0, 0, 0, 0);
      #2;
      rstnn = 1'b0;
      #1;
      chk("t8 count", count, 0);
      chk("t8 rd_valid", rd_valid, 0);
      chk("t8 wr_ready", wr_ready, 1);
      chk("t8 rd_beat", rd_beat, 0);
      q.delete();
      beat_m = 0;
      ovf_m = 0;
      @(negedge clk);
      rstnn = 1'b1;
      cycle("t8 after");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
